// File: rtl/prj7620_pkg.sv
// Shared definitions for the PAJ7620 I2C write path: FSM encoding,
// frame geometry and the per-phase SCL/SDA drive table.
package prj7620_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_ACK   = 3'd3,
        ST_STOP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // Device address byte for a PAJ7620 write (7-bit 0x73, R/W = 0).
    localparam logic [7:0] PAJ_WR_ADDR  = 8'hE6;
    // Clock cycles (phases q0..q3) per SCL bit period.
    localparam int         QTR_PER_BIT  = 4;
    // Address, register, data.
    localparam int         BYTES_PER_WR = 3;

    // Returns {scl, sda_oe} for a given state and phase. bit_v is the data
    // bit currently on the wire (only meaningful in ST_DATA).
    function automatic logic [1:0] phase_drive(input state_t st,
                                               input logic [1:0] q,
                                               input logic bit_v);
        logic [1:0] drv;
        drv = 2'b10;
        case (st)
            // SCL stays high; SDA falls halfway through -> START condition.
            ST_START: drv = {1'b1, q[1]};
            // SCL low in q0/q1 so SDA only moves while the clock is low.
            ST_DATA:  drv = {q[1], ~bit_v};
            ST_ACK:   drv = {q[1], 1'b0};
            // SCL rises at q1, SDA released at q3 -> STOP condition.
            ST_STOP:  drv = {(q != 2'd0), (q != 2'd3)};
            default:  drv = 2'b10;
        endcase
        return drv;
    endfunction

endpackage

// File: rtl/prj7620_i2c_wr.sv
// Serialises one 24-bit {addr, reg, data} word as a complete I2C write
// (START, 3 bytes + ACK slots, STOP) on open-drain SCL/SDA, then pulses
// i2c_end for one cycle. All pad-facing outputs are registered.
//
// Handshake: i2c_start is a one-cycle request that is accepted only when
// the engine is idle (busy = 0 and not in the DONE cycle); cfg_data is
// captured in that same cycle. Requests at any other time are dropped.
// Completion is signalled by exactly one i2c_end pulse per accepted request,
// unless sys_rst cuts the frame short, in which case no pulse is produced.
module prj7620_i2c_wr
    import prj7620_pkg::*;
#(
    parameter bit ACK_CHK = 1'b1
) (
    input  logic        i2c_clk,
    input  logic        sys_rst,
    input  logic        i2c_start,
    input  logic [23:0] cfg_data,
    input  logic        sda_in,
    output logic        scl,
    output logic        sda_oe,
    output logic        busy,
    output logic        i2c_end,
    output logic        ack_err,
    output logic [2:0]  dbg_state
);

    localparam logic [1:0] Q_LAST    = 2'(QTR_PER_BIT - 1);
    localparam logic [1:0] BYTE_LAST = 2'(BYTES_PER_WR - 1);
    localparam logic [1:0] Q_SAMPLE  = 2'd2;

    state_t      state, nxt_state;
    logic [1:0]  q, nxt_q;
    logic [2:0]  bit_idx, nxt_bit;
    logic [1:0]  byte_idx, nxt_byte;
    logic [23:0] shreg, nxt_shreg;
    logic        ack_smp;
    logic [1:0]  drive;
    logic        nack_abort;

    assign dbg_state  = state;
    // A sampled high level in the ACK slot is a NACK; only acted on when checking.
    assign nack_abort = ack_smp & ACK_CHK;

    // Next-state, phase counter and shift-register update.
    always_comb begin
        nxt_state = state;
        nxt_q     = q;
        nxt_bit   = bit_idx;
        nxt_byte  = byte_idx;
        nxt_shreg = shreg;
        if (state inside {ST_START, ST_DATA, ST_ACK, ST_STOP}) begin
            nxt_q = q + 2'd1;
        end
        case (state)
            ST_IDLE: begin
                if (i2c_start) begin
                    nxt_state = ST_START;
                    nxt_q     = 2'd0;
                    nxt_shreg = cfg_data;
                end
            end
            ST_START: begin
                if (q == Q_LAST) begin
                    nxt_state = ST_DATA;
                    nxt_bit   = 3'd7;
                    nxt_byte  = 2'd0;
                end
            end
            ST_DATA: begin
                if (q == Q_LAST) begin
                    // MSB of shreg is always the bit on the wire.
                    nxt_shreg = {shreg[22:0], 1'b0};
                    if (bit_idx == 3'd0) begin
                        nxt_state = ST_ACK;
                    end else begin
                        nxt_bit = bit_idx - 3'd1;
                    end
                end
            end
            ST_ACK: begin
                if (q == Q_LAST) begin
                    if (nack_abort) begin
                        nxt_state = ST_STOP;
                    end else if (byte_idx < BYTE_LAST) begin
                        nxt_state = ST_DATA;
                        nxt_byte  = byte_idx + 2'd1;
                        nxt_bit   = 3'd7;
                    end else begin
                        nxt_state = ST_STOP;
                    end
                end
            end
            ST_STOP: begin
                if (q == Q_LAST) begin
                    nxt_state = ST_DONE;
                end
            end
            ST_DONE: begin
                nxt_state = ST_IDLE;
                nxt_q     = 2'd0;
                nxt_bit   = 3'd0;
                nxt_byte  = 2'd0;
            end
            default: begin
                nxt_state = ST_IDLE;
                nxt_q     = 2'd0;
            end
        endcase
        // Outputs are registered from the upcoming state/phase so the pads
        // change on the same edge that the FSM moves.
        drive = phase_drive(nxt_state, nxt_q, nxt_shreg[23]);
    end

    // Transaction FSM with registered pad, status and completion outputs.
    always_ff @(posedge i2c_clk) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            q        <= 2'd0;
            bit_idx  <= 3'd0;
            byte_idx <= 2'd0;
            shreg    <= 24'd0;
            ack_smp  <= 1'b0;
            scl      <= 1'b1;
            sda_oe   <= 1'b0;
            busy     <= 1'b0;
            i2c_end  <= 1'b0;
            ack_err  <= 1'b0;
        end else begin
            state    <= nxt_state;
            q        <= nxt_q;
            bit_idx  <= nxt_bit;
            byte_idx <= nxt_byte;
            shreg    <= nxt_shreg;
            scl      <= drive[1];
            sda_oe   <= drive[0];
            busy     <= (nxt_state inside {ST_START, ST_DATA, ST_ACK, ST_STOP});
            i2c_end  <= (nxt_state == ST_DONE);
            // SDA is sampled mid-way through SCL high.
            if (state == ST_ACK && q == Q_SAMPLE) begin
                ack_smp <= sda_in;
            end
            if (state == ST_IDLE && i2c_start) begin
                ack_err <= 1'b0;
            end else if (state == ST_ACK && q == Q_SAMPLE && sda_in && ACK_CHK) begin
                ack_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prj7620_i2c_wr.sv
// Directed + randomized bench for prj7620_i2c_wr. Two instances run in
// lock-step: one with NACK checking enabled, one with it disabled. Expected
// per-cycle pad/status values come from a frame model built out of the
// protocol's segment rules (START, 8 bits + ACK per byte, STOP, DONE).
module tb_prj7620_i2c_wr;
    import prj7620_pkg::*;

    logic i2c_clk = 1'b0;
    always #5 i2c_clk = ~i2c_clk;

    logic        sys_rst;
    logic        i2c_start;
    logic [23:0] cfg_data;
    logic        slave_low;

    logic        sda_in1, scl1, oe1, busy1, end1, err1;
    logic [2:0]  st1;
    logic        sda_in0, scl0, oe0, busy0, end0, err0;
    logic [2:0]  st0;

    // Open-drain bus: low if either master or slave pulls, else pulled up.
    assign sda_in1 = ~(oe1 | slave_low);
    assign sda_in0 = ~(oe0 | slave_low);

    prj7620_i2c_wr #(.ACK_CHK(1'b1)) dut1 (
        .i2c_clk(i2c_clk), .sys_rst(sys_rst), .i2c_start(i2c_start),
        .cfg_data(cfg_data), .sda_in(sda_in1), .scl(scl1), .sda_oe(oe1),
        .busy(busy1), .i2c_end(end1), .ack_err(err1), .dbg_state(st1)
    );

    prj7620_i2c_wr #(.ACK_CHK(1'b0)) dut0 (
        .i2c_clk(i2c_clk), .sys_rst(sys_rst), .i2c_start(i2c_start),
        .cfg_data(cfg_data), .sda_in(sda_in0), .scl(scl0), .sda_oe(oe0),
        .busy(busy0), .i2c_end(end0), .ack_err(err0), .dbg_state(st0)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge i2c_clk) cyc <= cyc + 1;

    logic [3:0] mq[$];
    logic [3:0] exp1_q[$];
    logic [3:0] exp0_q[$];
    int         end_cyc[$];
    bit         exp_err1 = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic scl_v, input logic oe_v, input logic busy_v, input logic end_v);
        mq.push_back({scl_v, oe_v, busy_v, end_v});
    endtask

    // Builds the expected {scl, sda_oe, busy, i2c_end} for cycles k+1..k+ncyc.
    task automatic gen_model(input logic [23:0] cfg, input int nack, input bit chk,
                             input int rst_at, input int ncyc);
        logic [7:0] bv;
        bit stop_now;
        stop_now = 1'b0;
        mq.delete();
        push(1'b1, 1'b0, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1, 1'b0);
        for (int b = 0; b < 3; b++) begin
            if (!stop_now) begin
                bv = 8'(cfg >> (16 - 8 * b));
                for (int i = 7; i >= 0; i--)
                    for (int p = 0; p < 4; p++) push((p >= 2), ~bv[i], 1'b1, 1'b0);
                for (int p = 0; p < 4; p++) push((p >= 2), 1'b0, 1'b1, 1'b0);
                if (chk && b == nack) stop_now = 1'b1;
            end
        end
        push(1'b0, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b1, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b1, 1'b0);
        push(1'b1, 1'b0, 1'b0, 1'b1);
        if (rst_at > 0)
            while (mq.size() > rst_at) void'(mq.pop_back());
        while (mq.size() < ncyc) push(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    // One request; the slave ACKs every byte except byte 'nack' (-1 = none).
    task automatic run_frame(input logic [23:0] cfg, input int nack, input int glitch_at,
                             input int rst_at, input int ncyc);
        logic   prev_scl;
        logic   bits[$];
        logic [23:0] dec;
        logic [2:0]  acks;
        int     ends1, ends0;
        bit     full_ack;
        full_ack = (nack < 0 || nack > 2);
        gen_model(cfg, nack, 1'b1, rst_at, ncyc);
        exp1_q = mq;
        gen_model(cfg, nack, 1'b0, rst_at, ncyc);
        exp0_q = mq;

        @(negedge i2c_clk);
        check("ack_err hold", 32'(err1), 32'(exp_err1));
        i2c_start = 1'b1;
        cfg_data  = cfg;
        @(posedge i2c_clk);
        prev_scl = 1'b1;
        ends1 = 0;
        ends0 = 0;
        bits.delete();
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge i2c_clk);
            i2c_start = (c == glitch_at);
            if (c == glitch_at) cfg_data = 24'($urandom);
            sys_rst   = (c == rst_at);
            slave_low = 1'b0;
            for (int b = 0; b < 3; b++)
                if (c >= 37 + 36 * b && c <= 40 + 36 * b && b != nack) slave_low = 1'b1;
            #1;
            check($sformatf("wave chk1 c%0d", c), 32'({scl1, oe1, busy1, end1}), 32'(exp1_q[c-1]));
            check($sformatf("wave chk0 c%0d", c), 32'({scl0, oe0, busy0, end0}), 32'(exp0_q[c-1]));
            if (c == 1) begin
                check("ack_err clr chk1", 32'(err1), 32'd0);
                check("ack_err clr chk0", 32'(err0), 32'd0);
            end
            if (end1) begin
                ends1++;
                end_cyc.push_back(cyc);
            end
            if (end0) ends0++;
            if (!prev_scl && scl1) bits.push_back(sda_in1);
            prev_scl = scl1;
        end
        i2c_start = 1'b0;
        sys_rst   = 1'b0;
        slave_low = 1'b0;

        exp_err1 = (rst_at == 0 && !full_ack);
        check("ack_err chk1", 32'(err1), 32'(exp_err1));
        check("ack_err chk0", 32'(err0), 32'd0);
        check("end count chk1", 32'(ends1), (rst_at == 0) ? 32'd1 : 32'd0);
        check("end count chk0", 32'(ends0), (rst_at == 0) ? 32'd1 : 32'd0);
        if (full_ack && rst_at == 0) begin
            // 27 data/ACK rises plus the STOP rise.
            check("scl rises", 32'(bits.size()), 32'd28);
            if (bits.size() >= 27) begin
                for (int b = 0; b < 3; b++) begin
                    for (int i = 0; i < 8; i++) dec[23 - 8 * b - i] = bits[9 * b + i];
                    acks[b] = bits[9 * b + 8];
                end
                check("serial bytes", 32'(dec), 32'(cfg));
                check("ack slots", 32'(acks), 32'd0);
            end
        end
    endtask

    initial begin
        sys_rst   = 1'b1;
        i2c_start = 1'b0;
        cfg_data  = 24'd0;
        slave_low = 1'b0;
        repeat (3) @(posedge i2c_clk);
        @(negedge i2c_clk);
        check("rst scl", 32'(scl1), 32'd1);
        check("rst sda_oe", 32'(oe1), 32'd0);
        check("rst busy", 32'(busy1), 32'd0);
        check("rst end", 32'(end1), 32'd0);
        check("rst ack_err", 32'(err1), 32'd0);
        check("rst state", 32'(st1), 32'(ST_IDLE));
        sys_rst = 1'b0;

        // Nominal frame.
        run_frame(24'hE6EF00, -1, 0, 0, 120);
        // Address-byte NACK: chk1 stops after the first ACK slot.
        run_frame({PAJ_WR_ADDR, 16'($urandom)}, 0, 0, 0, 120);
        repeat (3) @(negedge i2c_clk);
        check("ack_err held idle", 32'(err1), 32'd1);
        // Request in mid-frame is dropped.
        run_frame({PAJ_WR_ADDR, 16'($urandom)}, -1, 50, 0, 120);
        // Reset in the middle of byte 1.
        run_frame({PAJ_WR_ADDR, 16'($urandom)}, -1, 0, 60, 70);
        check("state after rst", 32'(st1), 32'(ST_IDLE));
        // Back-to-back at minimum spacing.
        end_cyc.delete();
        run_frame(24'hE63707, -1, 0, 0, 117);
        run_frame(24'hE63817, -1, 0, 0, 120);
        check("b2b end pulses", 32'(end_cyc.size()), 32'd2);
        if (end_cyc.size() == 2)
            check("b2b spacing", 32'(end_cyc[1] - end_cyc[0]), 32'd118);
        // Randomized frames and NACK positions (3 = all bytes ACKed).
        repeat (6) begin
            run_frame({PAJ_WR_ADDR, 16'($urandom)}, int'($urandom_range(0, 4)) - 1, 0, 0, 120);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
